// File: rtl/control_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// control_sequencer_pkg
// Shared definitions for the control sequencer: FSM state encoding, bit
// positions inside the 13-bit control word, the two I/O opcodes, the set of
// control bits that commit architectural state, and the illegal-decode word.
// ----------------------------------------------------------------------------
package control_sequencer_pkg;

   typedef enum logic [1:0] {
      state_fetch   = 2'd0,
      state_exec    = 2'd1,
      state_wait_io = 2'd2,
      state_halt    = 2'd3
   } state_t;

   localparam int ctrl_w = 13;

   // Control word bit map (identical for decode ROM output and gated ctrl).
   localparam int bit_inc_pc     = 12;
   localparam int bit_load_pc    = 11;
   localparam int bit_load_a     = 10;
   localparam int bit_load_flags = 9;
   localparam int bit_alu_sel_hi = 8;
   localparam int bit_alu_sel_lo = 6;
   localparam int bit_cs_ram     = 5;
   localparam int bit_we_ram     = 4;
   localparam int bit_oe_alu     = 3;
   localparam int bit_oe_in      = 2;
   localparam int bit_oe_oprnd   = 1;
   localparam int bit_load_out   = 0;

   localparam logic [3:0] op_in  = 4'b0101;
   localparam logic [3:0] op_out = 4'b1101;

   // Bits that change architectural state; they may only reach ctrl in the
   // cycle an instruction actually completes.
   localparam logic [ctrl_w-1:0] commit_mask =
        (13'd1 << bit_inc_pc)     | (13'd1 << bit_load_pc)
      | (13'd1 << bit_load_a)     | (13'd1 << bit_load_flags)
      | (13'd1 << bit_we_ram)     | (13'd1 << bit_load_out);

   // Decode ROM returns all-ones for an opcode/flag combination it does not
   // implement.
   localparam logic [ctrl_w-1:0] illegal_word = 13'h1fff;

endpackage

// File: rtl/ctrl_flags_reg.sv
// ----------------------------------------------------------------------------
// ctrl_flags_reg
// Carry/zero flag register with load enable. Captures the ALU flags only in
// cycles where the committed control word asserts load_flags.
//   clock, reset   : clock, synchronous active-high reset (flags -> 0)
//   load           : committed load_flags
//   c_in, z_in     : ALU carry / zero
//   c_reg, z_reg   : held flags, fed back into the decode address
// ----------------------------------------------------------------------------
module ctrl_flags_reg (
   input  logic clock,
   input  logic reset,
   input  logic load,
   input  logic c_in,
   input  logic z_in,
   output logic c_reg,
   output logic z_reg
);

   // NOTE: registers are written with <= so every flop samples the values
   // from before the edge; blocking = here would create ordering races.
   always_ff @(posedge clock) begin
      if (reset) begin
         c_reg <= 1'b0;
         z_reg <= 1'b0;
      end else if (load) begin
         c_reg <= c_in;
         z_reg <= z_in;
      end
   end

endmodule

// File: rtl/control_sequencer.sv
// ----------------------------------------------------------------------------
// control_sequencer
// Microsequencer that walks FETCH -> EXEC (-> WAIT_IO) per instruction, gates
// the externally decoded control word so state only commits when an
// instruction completes, and supports halt / single-step / illegal-decode.
//   clock, reset      : clock, synchronous active-high reset
//   enable, halt_req  : run mode / stop at next instruction boundary
//   step              : execute one instruction while halted
//   program_byte      : ROM word, [7:4] opcode, [3:0] operand
//   c_in, z_in        : ALU carry / zero
//   signals           : decode ROM word addressed by decode_addr
//   decode_addr       : {opcode, C, Z, phase}
//   ctrl              : gated control word
//   oprnd             : latched operand
//   in_valid/in_ready : input handshake for IN
//   out_valid/out_ack : output handshake for OUT
//   phase, halted, err: status (err is sticky until reset)
// ----------------------------------------------------------------------------
module control_sequencer
   import control_sequencer_pkg::*;
(
   input  logic              clock,
   input  logic              reset,
   input  logic              enable,
   input  logic              halt_req,
   input  logic              step,
   input  logic [7:0]        program_byte,
   input  logic              c_in,
   input  logic              z_in,
   input  logic [ctrl_w-1:0] signals,
   output logic [6:0]        decode_addr,
   output logic [ctrl_w-1:0] ctrl,
   output logic [3:0]        oprnd,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              out_valid,
   input  logic              out_ack,
   output logic              phase,
   output logic              halted,
   output logic              err
);

   state_t     state;
   logic [3:0] opcode;
   logic       one_shot;
   logic       err_q;
   logic       c_reg;
   logic       z_reg;
   logic       active;
   logic       illegal;
   logic       complete;

   assign active  = (state == state_exec) || (state == state_wait_io);
   assign illegal = (signals == illegal_word)
                    && ((state == state_fetch) || (state == state_exec));

   // An instruction completes in EXEC/WAIT_IO once its handshake (if any)
   // is satisfied; ordinary opcodes complete in their single EXEC cycle.
   // NOTE: every variable written in always_comb gets a default first so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      complete = 1'b0;
      if (active) begin
         if (opcode == op_in)
            complete = in_valid;
         else if (opcode == op_out)
            complete = out_ack;
         else
            complete = 1'b1;
      end
   end

   always_comb begin
      ctrl = '0;
      if (!reset && !illegal) begin
         case (state)
            state_fetch:               ctrl = signals;
            state_exec, state_wait_io: ctrl = complete ? signals
                                                       : (signals & ~commit_mask);
            default:                   ctrl = '0;
         endcase
      end
   end

   ctrl_flags_reg u_flags (
      .clock (clock),
      .reset (reset),
      .load  (ctrl[bit_load_flags]),
      .c_in  (c_in),
      .z_in  (z_in),
      .c_reg (c_reg),
      .z_reg (z_reg)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= state_fetch;
         opcode   <= 4'd0;
         oprnd    <= 4'd0;
         one_shot <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         case (state)
            state_fetch: begin
               if (illegal) begin
                  err_q    <= 1'b1;
                  one_shot <= 1'b0;
                  state    <= state_halt;
               end else begin
                  opcode <= program_byte[7:4];
                  oprnd  <= program_byte[3:0];
                  state  <= state_exec;
               end
            end
            state_exec, state_wait_io: begin
               if (illegal) begin
                  err_q    <= 1'b1;
                  one_shot <= 1'b0;
                  state    <= state_halt;
               end else if (complete) begin
                  // Instruction boundary: a pending stop or a finished
                  // single step parks the sequencer.
                  one_shot <= 1'b0;
                  if (halt_req || !enable || one_shot)
                     state <= state_halt;
                  else
                     state <= state_fetch;
               end else begin
                  state <= state_wait_io;
               end
            end
            state_halt: begin
               // Free-run takes priority over a simultaneous step.
               if (enable && !halt_req) begin
                  one_shot <= 1'b0;
                  state    <= state_fetch;
               end else if (step) begin
                  one_shot <= 1'b1;
                  state    <= state_fetch;
               end
            end
            default: state <= state_fetch;
         endcase
      end
   end

   assign phase       = active;
   assign decode_addr = {opcode, c_reg, z_reg, phase};
   assign in_ready    = !reset && active && (opcode == op_in);
   assign out_valid   = !reset && active && (opcode == op_out);
   assign halted      = !reset && (state == state_halt);
   assign err         = !reset && err_q;

endmodule

// File: tb/tb_control_sequencer.sv
// ----------------------------------------------------------------------------
// tb_control_sequencer
// Instruction-level reference model drives stimulus and queues the expected
// per-cycle outputs; a negedge monitor pops and compares.
// ----------------------------------------------------------------------------
module tb_control_sequencer;

   logic        clock = 1'b0;
   logic        reset;
   logic        enable;
   logic        halt_req;
   logic        step;
   logic [7:0]  program_byte;
   logic        c_in;
   logic        z_in;
   logic [12:0] signals;
   logic [6:0]  decode_addr;
   logic [12:0] ctrl;
   logic [3:0]  oprnd;
   logic        in_valid;
   logic        in_ready;
   logic        out_valid;
   logic        out_ack;
   logic        phase;
   logic        halted;
   logic        err;
   logic        force_illegal;

   always #5 clock = ~clock;

   control_sequencer dut (
      .clock        (clock),
      .reset        (reset),
      .enable       (enable),
      .halt_req     (halt_req),
      .step         (step),
      .program_byte (program_byte),
      .c_in         (c_in),
      .z_in         (z_in),
      .signals      (signals),
      .decode_addr  (decode_addr),
      .ctrl         (ctrl),
      .oprnd        (oprnd),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .out_valid    (out_valid),
      .out_ack      (out_ack),
      .phase        (phase),
      .halted       (halted),
      .err          (err)
   );

   // Bits that commit state: inc_pc, load_pc, load_a, load_flags, we_ram, load_out.
   localparam logic [12:0] mask = 13'h1e11;

   // External decode ROM. Phase 0 is the fetch microword (inc_pc only).
   function automatic logic [12:0] rom(input logic [6:0] a);
      logic [3:0] op;
      logic       c;
      logic       z;
      op = a[6:3];
      c  = a[2];
      z  = a[1];
      if (!a[0]) return 13'h1000;
      case (op)
         4'h0:    return c ? 13'h0802 : 13'h0000;   // JC: load_pc|oe_oprnd
         4'h1:    return 13'h0648;                  // ADDI: load_a|load_flags|alu1|oe_alu
         4'h4:    return 13'h0402;                  // LIT: load_a|oe_oprnd
         4'h5:    return 13'h0404;                  // IN: load_a|oe_in
         4'hd:    return 13'h0089;                  // OUT: alu2|oe_alu|load_out
         default: return {3'b000, z, op, 2'b11, c, 2'b10};
      endcase
   endfunction

   assign signals = force_illegal ? 13'h1fff : rom(decode_addr);

   typedef struct {
      logic [12:0] ctrl;
      logic [6:0]  da;
      logic        in_ready;
      logic        out_valid;
      logic        phase;
      logic        halted;
      logic        err;
      logic [3:0]  oprnd;
      string       tag;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp  = 0;
   int   n_fail = 0;

   // Reference model state (architectural view).
   logic [3:0] m_op;
   logic [3:0] m_oprnd;
   logic       m_c;
   logic       m_z;
   logic       m_err;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h @%0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every cycle with a queued expectation is compared mid-cycle.
   exp_t e;
   always @(negedge clock) begin
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check({e.tag, ".ctrl"},      32'(ctrl),        32'(e.ctrl));
         check({e.tag, ".da"},        32'(decode_addr), 32'(e.da));
         check({e.tag, ".in_ready"},  32'(in_ready),    32'(e.in_ready));
         check({e.tag, ".out_valid"}, 32'(out_valid),   32'(e.out_valid));
         check({e.tag, ".phase"},     32'(phase),       32'(e.phase));
         check({e.tag, ".halted"},    32'(halted),      32'(e.halted));
         check({e.tag, ".err"},       32'(err),         32'(e.err));
         check({e.tag, ".oprnd"},     32'(oprnd),       32'(e.oprnd));
      end
   end

   task automatic exp_cycle(input logic [12:0] ectrl, input logic eir, input logic eov,
                            input logic eph, input logic ehl, input logic eer, input string tag);
      exp_t x;
      x.ctrl      = ectrl;
      x.da        = {m_op, m_c, m_z, eph};
      x.in_ready  = eir;
      x.out_valid = eov;
      x.phase     = eph;
      x.halted    = ehl;
      x.err       = eer;
      x.oprnd     = m_oprnd;
      x.tag       = tag;
      exp_q.push_back(x);
      @(posedge clock);
      #1;
   endtask

   task automatic fetch(input logic [7:0] pb);
      program_byte = pb;
      step         = 1'b0;
      in_valid     = 1'b0;
      out_ack      = 1'b0;
      c_in         = 1'($urandom);
      z_in         = 1'($urandom);
      exp_cycle(rom({m_op, m_c, m_z, 1'b0}), 1'b0, 1'b0, 1'b0, 1'b0, m_err, "fetch");
      m_op    = pb[7:4];
      m_oprnd = pb[3:0];
   endtask

   // One instruction's execute phase: n_wait handshake-less cycles for IN/OUT,
   // then the commit cycle. cz < 0 randomises the ALU flags.
   task automatic exec(input int n_wait, input int cz);
      logic [12:0] s;
      bit          is_in;
      bit          is_out;
      bit          last;
      int          waits;
      is_in  = (m_op == 4'h5);
      is_out = (m_op == 4'hd);
      waits  = (is_in || is_out) ? n_wait : 0;
      for (int i = 0; i <= waits; i++) begin
         last     = (i == waits);
         in_valid = is_in ? last : 1'($urandom);
         out_ack  = is_out ? last : 1'($urandom);
         if (cz < 0) begin
            c_in = 1'($urandom);
            z_in = 1'($urandom);
         end else begin
            c_in = cz[1];
            z_in = cz[0];
         end
         s = rom({m_op, m_c, m_z, 1'b1});
         exp_cycle(last ? s : (s & ~mask), is_in, is_out, 1'b1, 1'b0, m_err,
                   last ? "commit" : "wait");
         if (last && s[9]) begin
            m_c = c_in;
            m_z = z_in;
         end
      end
      in_valid = 1'b0;
      out_ack  = 1'b0;
   endtask

   task automatic halt_cycle(input logic st);
      step = st;
      c_in = 1'($urandom);
      z_in = 1'($urandom);
      exp_cycle(13'h0000, 1'b0, 1'b0, 1'b0, 1'b1, m_err, "halt");
      step = 1'b0;
   endtask

   initial begin
      reset = 1'b1; enable = 1'b0; halt_req = 1'b0; step = 1'b0;
      program_byte = 8'h00; c_in = 1'b0; z_in = 1'b0;
      in_valid = 1'b0; out_ack = 1'b0; force_illegal = 1'b0;
      @(posedge clock);
      #1;
      m_op = 4'd0; m_oprnd = 4'd0; m_c = 1'b0; m_z = 1'b0; m_err = 1'b0;
      exp_cycle(13'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "reset");

      // LIT 0xA right after reset release.
      reset = 1'b0; enable = 1'b1;
      fetch(8'h4a);
      check("lit_opcode", 32'(decode_addr[6:3]), 32'h4);
      check("lit_oprnd",  32'(oprnd),            32'ha);
      check("lit_load_a", 32'(ctrl[10]),         32'h1);
      exec(0, -1);
      check("lit_back_in_fetch", 32'({phase, halted}), 32'h0);

      // ADDI with C=1,Z=0 then JC sees the new flags.
      fetch(8'h13);
      exec(0, 2);
      fetch(8'h07);
      check("jc_decode_addr", 32'(decode_addr), 32'b0000101);
      exec(0, -1);

      // IN stalled three cycles.
      fetch(8'h5c);
      exec(3, -1);

      // Random free-running program.
      for (int i = 0; i < 40; i++) begin
         fetch({4'($urandom_range(0, 15)), 4'($urandom)});
         exec($urandom_range(0, 3), -1);
      end

      // OUT with halt_req raised during EXEC and a late ack.
      fetch(8'hd3);
      halt_req = 1'b1;
      exec(2, -1);
      halt_cycle(1'b0);
      halt_cycle(1'b0);
      check("halt_after_out", 32'(halted), 32'h1);

      // Single step: exactly one instruction, then back to HALT.
      halt_req = 1'b0; enable = 1'b0;
      halt_cycle(1'b1);
      fetch(8'h4f);
      exec(0, -1);
      halt_cycle(1'b0);
      halt_cycle(1'b0);
      check("halt_after_step", 32'(halted), 32'h1);

      // step together with enable: free-run wins.
      enable = 1'b1;
      halt_cycle(1'b1);
      fetch(8'h21);
      exec(0, -1);
      fetch(8'h4b);
      exec(0, -1);
      fetch(8'h30);
      enable = 1'b0;
      exec(0, -1);
      halt_cycle(1'b0);

      // Illegal decode in EXEC.
      enable = 1'b1;
      halt_cycle(1'b0);
      fetch(8'h42);
      force_illegal = 1'b1;
      enable        = 1'b0;
      exp_cycle(13'h0000, 1'b0, 1'b0, 1'b1, 1'b0, m_err, "illegal");
      force_illegal = 1'b0;
      m_err = 1'b1;
      halt_cycle(1'b0);
      check("illegal_err",    32'(err),    32'h1);
      check("illegal_halted", 32'(halted), 32'h1);
      enable = 1'b1;
      halt_cycle(1'b0);
      fetch(8'h4c);
      exec(0, -1);

      // Reset in the middle of an IN wait: no commit, back to FETCH.
      fetch(8'h57);
      in_valid = 1'b0;
      exp_cycle(rom({m_op, m_c, m_z, 1'b1}) & ~mask, 1'b1, 1'b0, 1'b1, 1'b0, m_err, "in_wait");
      reset    = 1'b1;
      in_valid = 1'b1;
      exp_cycle(13'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "reset_mid_wait");
      reset    = 1'b0;
      in_valid = 1'b0;
      m_op = 4'd0; m_oprnd = 4'd0; m_c = 1'b0; m_z = 1'b0; m_err = 1'b0;
      fetch(8'h4d);
      check("post_reset_err", 32'(err), 32'h0);
      exec(0, -1);
      enable = 1'b0;
      fetch(8'h4e);
      exec(0, -1);
      halt_cycle(1'b0);

      check("queue_drained", 32'(exp_q.size()), 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL have ports: clock  in  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have: reset  in  1  synchronous, active-high; takes effect on the rising edge of clock.
REQ-003 SHALL have: enable  in  1  run mode; halt_req  in  1  stop at next instruction boundary; step  in  1  single-instruction request while halted.
REQ-004 SHALL have: program_byte  in  8  ROM word, [7:4] opcode, [3:0] operand.
REQ-005 SHALL have: c_in, z_in  in  1 each  ALU carry/zero.
REQ-006 SHALL have: signals  in  13  decode word from the decode ROM.
REQ-007 SHALL have: decode_addr  out  7  {opcode[3:0], C, Z, phase}.
REQ-008 SHALL have: ctrl  out  13  gated control word, same bit map as signals: [12] inc_pc, [11] load_pc, [10] load_a, [9] load_flags, [8:6] alu_sel, [5] cs_ram, [4] we_ram, [3] oe_alu, [2] oe_in, [1] oe_oprnd, [0] load_out.
REQ-009 SHALL have: oprnd  out  4; in_valid  in  1; in_ready  out  1; out_valid  out  1; out_ack  in  1; phase  out  1; halted  out  1; err  out  1.

Function
REQ-010 SHALL implement states FETCH, EXEC, WAIT_IO, HALT; phase = 1 in EXEC and WAIT_IO, else 0.
REQ-011 In FETCH: ctrl = signals, with decode_addr phase bit = 0. On the clock edge, opcode and oprnd SHALL load from program_byte, and the state SHALL go to EXEC.
REQ-012 In EXEC: decode_addr = {opcode, C_reg, Z_reg, 1}; C_reg/Z_reg are internal flag registers, not c_in/z_in.
REQ-013 Commit mask = inc_pc, load_pc, load_a, load_flags, we_ram, load_out. These bits SHALL be forced to 0 in any cycle in which the instruction does not complete.
REQ-014 IN (opcode 0101): in_ready = 1 in EXEC and WAIT_IO.
- in_valid = 1: commit and go to FETCH in the same cycle.
- in_valid = 0: gate the commit mask and go to / stay in WAIT_IO.
REQ-015 OUT (opcode 1101): out_valid = 1 in EXEC and WAIT_IO; load_out is committed only in the cycle with out_ack = 1. Until then the state SHALL go to / stay in WAIT_IO.
REQ-016 All other opcodes SHALL commit in their single EXEC cycle and return to FETCH: 2-cycle instruction latency.
REQ-017 On any cycle where committed load_flags = 1, C_reg <= c_in and Z_reg <= z_in; otherwise the flags SHALL hold.
REQ-018 Instruction boundary = the commit cycle.
- At a boundary, halt_req = 1 or enable = 0 SHALL go to HALT instead of FETCH.
- halt_req SHALL never abort an instruction mid-way.
REQ-019 In HALT: ctrl = 0, halted = 1.
- enable = 1 with halt_req = 0 SHALL go to FETCH.
- Otherwise, step = 1 SHALL go to FETCH with a one-shot flag set; the next boundary then returns to HALT and clears the flag.
REQ-020 In FETCH or EXEC, signals = all-ones (13'h1FFF, the illegal-decode word) SHALL:
- gate all of ctrl;
- set sticky err;
- go to HALT.
err SHALL clear only on reset.
REQ-021 Simultaneous step and enable in HALT: enable SHALL win (free-run, no one-shot).
REQ-022 in_ready and out_valid SHALL be 0 in FETCH and HALT.

Reset
REQ-023 While reset = 1, ctrl SHALL be 0 and in_ready, out_valid, halted and err SHALL be 0.
REQ-024 On the reset edge: state <= FETCH; opcode, oprnd, C_reg, Z_reg, one-shot flag and err <= 0.
REQ-025 Reset SHALL override any state, including WAIT_IO mid-handshake, with no commit in that cycle.

Structure
REQ-026 A shared package SHALL hold:
- the state encoding;
- the 13-bit control bit-index constants;
- the opcode constants IN = 4'b0101 and OUT = 4'b1101;
- the commit mask;
- the illegal-decode word.
REQ-027 The flag register (C_reg/Z_reg with load enable) SHALL be a sub-module named ctrl_flags_reg; the decode ROM stays external.

Verification
REQ-028 Reset, then enable = 1, program_byte = 8'h4A, decode returning LIT → next cycle opcode = 4, oprnd = A, ctrl[10] = 1; FETCH two cycles after reset release.
REQ-029 IN with in_valid held 0 for 3 cycles, then 1 → ctrl commit bits 0 for 3 cycles, in_ready = 1 throughout, one commit cycle, then FETCH.
REQ-030 ADDI with c_in = 1, z_in = 0, followed by JC → decode_addr = {0000, 1, 0, 1} during JC EXEC.
REQ-031 halt_req asserted mid-EXEC of OUT with out_ack delayed 2 cycles → instruction completes with load_out = 1, then halted = 1. A step pulse then executes exactly one instruction and returns to HALT.
REQ-032 Drive signals = 13'h1FFF in EXEC → ctrl = 0, err = 1, halted = 1 next cycle. Reset asserted during WAIT_IO → FETCH, err = 0, no commit.
